// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the 8-tap convolution sequencer.
package conv_pkg;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned N         = 8;
    localparam int unsigned N_OUT     = 2 * N - 1;
    localparam int unsigned ACC_W     = 2 * DATA_W + $clog2(N);
    localparam int unsigned IDX_W     = $clog2(N);
    localparam int unsigned OUT_IDX_W = $clog2(N_OUT);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        FLUSH,
        STREAM
    } conv_state_e;
endpackage

// File: rtl/conv_mac_stage.sv
// Registered unsigned multiplier with a tag/valid pipeline register alongside,
// giving one cycle of latency from issue to accumulate.
module conv_mac_stage #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_a,
    input  logic [DATA_W-1:0]     in_b,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    output logic [2*DATA_W-1:0]   out_prod,
    output logic [TAG_W-1:0]      out_tag
);
    localparam int unsigned P_W = 2 * DATA_W;

    logic             valid_q, valid_d;
    logic [P_W-1:0]   prod_q, prod_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    always_comb begin
        valid_d = in_valid;
        prod_d  = in_valid ? P_W'(in_a) * P_W'(in_b) : '0;
        tag_d   = in_valid ? in_tag : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            prod_q  <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            prod_q  <= prod_d;
            tag_q   <= tag_d;
        end
    end

    assign out_valid = valid_q;
    assign out_prod  = prod_q;
    assign out_tag   = tag_q;
endmodule

// File: rtl/conv_sched.sv
// Linear-convolution sequencer: captures S/H frames, time-shares one multiplier
// over all N*N pairs into 2N-1 accumulator bins, then streams the bins out.
module conv_sched #(
    parameter int unsigned DATA_W = conv_pkg::DATA_W,
    parameter int unsigned N      = conv_pkg::N,
    parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(N),
    localparam int unsigned N_OUT = 2 * N - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [N*DATA_W-1:0]        s_flat,
    input  logic [N*DATA_W-1:0]        h_flat,
    output logic                       busy,
    output logic                       done,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_W-1:0]           out_data,
    output logic [$clog2(N_OUT)-1:0]   out_idx,
    output logic                       out_last
);
    import conv_pkg::*;

    localparam int unsigned CNT_W = $clog2(N);
    localparam int unsigned TAG_W = $clog2(N_OUT);

    conv_state_e state_q, state_d;

    logic [CNT_W-1:0]  i_q, i_d, j_q, j_d;
    logic [TAG_W-1:0]  idx_q, idx_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] s_q [N];
    logic [DATA_W-1:0] s_d [N];
    logic [DATA_W-1:0] h_q [N];
    logic [DATA_W-1:0] h_d [N];
    logic [ACC_W-1:0]  acc_q [N_OUT];
    logic [ACC_W-1:0]  acc_d [N_OUT];

    logic                mul_valid;
    logic [2*DATA_W-1:0] mul_prod;
    logic [TAG_W-1:0]    mul_tag;

    logic start_acc, issue, last_issue, last_beat, handshake;

    assign start_acc  = (state_q == IDLE) && start;
    assign issue      = (state_q == MAC);
    assign last_issue = (i_q == CNT_W'(N - 1)) && (j_q == CNT_W'(N - 1));
    assign last_beat  = (idx_q == TAG_W'(N_OUT - 1));
    assign handshake  = out_valid && out_ready;

    conv_mac_stage #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .in_a      (s_q[i_q]),
        .in_b      (h_q[j_q]),
        .in_tag    (TAG_W'(i_q) + TAG_W'(j_q)),
        .out_valid (mul_valid),
        .out_prod  (mul_prod),
        .out_tag   (mul_tag)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (start) state_d = MAC;
            MAC:    if (last_issue) state_d = FLUSH;
            FLUSH:  state_d = STREAM;
            STREAM: if (handshake && last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        out_valid = (state_q == STREAM);
    end

    always_comb begin
        i_d    = i_q;
        j_d    = j_q;
        idx_d  = idx_q;
        s_d    = s_q;
        h_d    = h_q;
        acc_d  = acc_q;
        done_d = (state_q == STREAM) && handshake && last_beat;

        // The final product lands during FLUSH, so accumulation runs on stage valid alone.
        if (mul_valid) acc_d[mul_tag] = acc_q[mul_tag] + ACC_W'(mul_prod);

        if (start_acc) begin
            for (int unsigned n = 0; n < N; n++) begin
                s_d[n] = s_flat[n*DATA_W +: DATA_W];
                h_d[n] = h_flat[n*DATA_W +: DATA_W];
            end
            for (int unsigned k = 0; k < N_OUT; k++) acc_d[k] = '0;
            i_d = '0;
            j_d = '0;
        end

        if (issue) begin
            if (j_q == CNT_W'(N - 1)) begin
                j_d = '0;
                i_d = i_q + 1'b1;
            end else begin
                j_d = j_q + 1'b1;
            end
        end

        if ((state_q == STREAM) && handshake) idx_d = last_beat ? '0 : idx_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_q    <= '0;
            j_q    <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
            for (int unsigned n = 0; n < N; n++) begin
                s_q[n] <= '0;
                h_q[n] <= '0;
            end
            for (int unsigned k = 0; k < N_OUT; k++) acc_q[k] <= '0;
        end else begin
            i_q    <= i_d;
            j_q    <= j_d;
            idx_q  <= idx_d;
            done_q <= done_d;
            s_q    <= s_d;
            h_q    <= h_d;
            acc_q  <= acc_d;
        end
    end

    assign done     = done_q;
    assign out_idx  = idx_q;
    assign out_last = out_valid && last_beat;
    assign out_data = out_valid ? acc_q[idx_q] : '0;
endmodule

// File: doc/conv_sched.md
# conv_sched

Sequencing controller for the 8-tap linear-convolution datapath. It captures one input frame S and one coefficient frame H, then time-shares a single registered multiplier across all N×N sample/coefficient pairs. Each product is accumulated into bin y[i+j]. The 2N−1 results are then streamed out through a valid/ready port. The block replaces free-running counters, demux and adder trees with one start/busy/done handshake and width-safe accumulation.

## Interface
- `DATA_W`, default 8: width of each S and H element (unsigned).
- `N`, default 8: taps per frame.
- `N_OUT`, default 2N−1 = 15: number of result bins (derived; not overridable).
- `ACC_W`, default 2·DATA_W+$clog2(N) = 19: accumulator and output width, which is overflow-free.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous reset, active-high.
- `start` input 1: request a convolution. Sampled only in IDLE.
- `s_flat` input N·DATA_W: S frame; element i is at bits [i·DATA_W +: DATA_W]. Captured on an accepted start.
- `h_flat` input N·DATA_W: H frame, same packing, captured on an accepted start.
- `busy` output 1: high from the cycle after an accepted start until the cycle of the `done` pulse.
- `done` output 1: one-cycle pulse after the final output handshake.
- `out_valid` output 1: result beat valid.
- `out_ready` input 1: sink accepts the beat.
- `out_data` output ACC_W: y[out_idx].
- `out_idx` output $clog2(N_OUT): bin index, 0..N_OUT−1.
- `out_last` output 1: high with out_idx = N_OUT−1.

## Operation
- **States:**
  - IDLE: on `start`, go to MAC.
  - MAC: runs N·N cycles, then goes to FLUSH.
  - FLUSH: runs 1 cycle, then goes to STREAM.
  - STREAM: on the final handshake, go to IDLE.
- **Accepted start (in IDLE):**
  - Latch `s_flat` and `h_flat` into internal frame registers.
  - Clear all N_OUT accumulators to 0.
  - Zero the counters i and j.
- **MAC:**
  - Each cycle, issue S[i]·H[j] to the multiplier stage together with tag k = i+j.
  - j increments every cycle. On j = N−1, j wraps to 0 and i increments.
  - Leave MAC after i = j = N−1.
  - Order is i-major.
- **Multiplier stage:** product and tag are registered, giving 1-cycle latency. In the next cycle, acc[tag] ← acc[tag] + product, zero-extended to ACC_W.
- **FLUSH:** absorbs the final in-flight product. No new issue.
- **STREAM:**
  - `out_valid` is high continuously. `out_data` = acc[idx].
  - idx advances only on `out_valid && out_ready`.
  - While stalled, out_data, out_idx and out_last hold stable.
  - The handshake at idx = N_OUT−1 returns the block to IDLE.
- **Arithmetic:**
  - Fully unsigned. No truncation, no saturation.
  - Maximum bin value is N·(2^DATA_W−1)², which is 520200 at defaults and fits in 19 bits.
- **`start` outside IDLE:** ignored, with no side effects. Frame inputs are don't-care outside the start cycle.
- **`rst` (any state, including mid-MAC or mid-STREAM):** next cycle the block is in IDLE. busy=0, done=0, out_valid=0, out_idx=0, out_last=0, out_data=0, accumulators and counters 0.

## Timing
- Start sampled at edge T.
  - busy=1 from T+1.
  - MAC occupies T+1..T+64.
  - FLUSH at T+65.
  - out_valid rises at T+66.
- With out_ready held high: beats are at T+66..T+80, with out_last at T+80.
- `done`=1 and busy=0 at T+81. `done` is the only pulse. The block is in IDLE at T+81, so a new `start` is accepted at edge T+81.
- Minimum frame period is 81 cycles. Backpressure adds one cycle per stalled beat.
- out_data is a registered/mux path from the accumulator array and is valid in the same cycle as out_valid.

## Structure
- `conv_pkg`:
  - DATA_W, N, N_OUT, ACC_W constants.
  - `conv_state_e` enum {IDLE, MAC, FLUSH, STREAM}.
  - index-width localparams.
- Sub-module `conv_mac_stage`:
  - Registered DATA_W×DATA_W unsigned multiply plus tag/valid pipeline register.
  - Synchronous clear on `rst`.
- `conv_sched` holds:
  - the FSM;
  - the i/j/idx counters;
  - the frame registers;
  - the accumulator array and output mux.

## Test plan
- **Impulse.** Stimulus: S=[1,0,0,0,0,0,0,0], H=[1..8], out_ready=1. Response: y=[1,2,3,4,5,6,7,8,0,0,0,0,0,0,0], out_last on beat 14, done at T+81.
- **Full-scale.** Stimulus: S=H=all 255. Response: y[0]=65025, y[7]=520200, y[14]=65025, y[k]=(min(k,14−k)+1)·65025. No overflow.
- **Backpressure.** Stimulus: random S/H; out_ready low on alternate cycles and held low for 5 cycles at idx 7. Response:
  - values match the golden model;
  - out_data and out_idx are stable while stalled;
  - done arrives exactly one cycle after the last handshake.
- **Start while busy.** Stimulus: pulse start with different S/H during MAC and during STREAM. Response: the first frame's results are unchanged and no second run occurs.
- **Reset mid-operation.** Stimulus: assert rst at T+30 (MAC), then start a new frame S=H=all 1. Response:
  - all outputs are 0 the cycle after rst;
  - the new frame gives y=[1,2,3,4,5,6,7,8,7,6,5,4,3,2,1], with no residue from the aborted frame.
- **Back-to-back.** Stimulus: start asserted in the done cycle with a new frame. Response: accepted at T+81, second results correct, busy low for exactly that one cycle.
